// File: rtl/adbg_pkg.sv
// Shared command and state types for the advanced-debug JTAG host.
package adbg_pkg;

   localparam int MAX_LEN_DEF = 64;

   typedef enum logic [1:0] {
      TAP_RESET = 2'd0,
      SHIFT_IR  = 2'd1,
      SHIFT_DR  = 2'd2
   } cmd_type_e;

   typedef enum logic [2:0] {
      IDLE,
      RST,
      HDR,
      SHIFT,
      TRL,
      RESP
   } host_state_e;

endpackage

// File: rtl/adbg_tck_gen.sv
// TCK divider: low for CLK_DIV cycles, high for CLK_DIV cycles, with single-cycle
// strobes on the clk_i edge where TCK rises or falls. Held low while disabled.
module adbg_tck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic en_i,
   output logic tck_o,
   output logic rise_o,
   output logic fall_o
);

   logic [7:0] cnt_q;
   logic       term;

   assign term   = (cnt_q == 8'(CLK_DIV - 1));
   assign rise_o = en_i && term && !tck_o;
   assign fall_o = en_i && term && tck_o;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
         tck_o <= 1'b0;
      end else if (!en_i) begin
         cnt_q <= '0;
         tck_o <= 1'b0;
      end else if (term) begin
         cnt_q <= '0;
         tck_o <= ~tck_o;
      end else begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

endmodule

// File: rtl/adbg_jtag_host.sv
// JTAG host: runs TAP_RESET / SHIFT_IR / SHIFT_DR scan commands from Run-Test/Idle
// back to Run-Test/Idle and returns the captured TDO bits.
module adbg_jtag_host
   import adbg_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [1:0]         cmd_type_i,
   input  logic [6:0]         cmd_len_i,
   input  logic [MAX_LEN-1:0] cmd_data_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [MAX_LEN-1:0] rsp_data_o,
   output logic               rsp_err_o,
   output logic               tck_o,
   output logic               tms_o,
   output logic               tdi_o,
   output logic               trstn_o,
   input  logic               tdo_i
);

   host_state_e        state_q, state_d;
   logic               tck_en, tck_rise, tck_fall;
   logic               accept, reject, last_bit;
   logic [2:0]         step_q, hdr_last;
   logic [6:0]         bit_cnt_q, len_q;
   logic [1:0]         type_q;
   logic [MAX_LEN-1:0] data_q;

   assign accept   = (state_q == IDLE) && cmd_valid_i && cmd_ready_o;
   assign reject   = (cmd_len_i == 7'd0) || ({25'd0, cmd_len_i} > 32'(MAX_LEN)) ||
                     (cmd_type_i == 2'd3);
   assign last_bit = (bit_cnt_q == len_q - 7'd1);
   assign hdr_last = (type_q == SHIFT_IR) ? 3'd3 : 3'd2;

   adbg_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .en_i   (tck_en),
      .tck_o  (tck_o),
      .rise_o (tck_rise),
      .fall_o (tck_fall)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      tck_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (reject)                        state_d = RESP;
               else if (cmd_type_i == TAP_RESET)  state_d = RST;
               else                               state_d = HDR;
            end
         end
         RST: begin
            tck_en = 1'b1;
            if (tck_fall && step_q == 3'd5) state_d = RESP;
         end
         HDR: begin
            tck_en = 1'b1;
            if (tck_fall && step_q == hdr_last) state_d = SHIFT;
         end
         SHIFT: begin
            tck_en = 1'b1;
            if (tck_rise && last_bit) state_d = TRL;
         end
         TRL: begin
            tck_en = 1'b1;
            if (tck_fall && step_q == 3'd2) state_d = RESP;
         end
         RESP: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pins and response: TMS/TDI for the next pulse are loaded on each TCK fall.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         tms_o       <= 1'b1;
         tdi_o       <= 1'b0;
         trstn_o     <= 1'b0;
         cmd_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_data_o  <= '0;
         step_q      <= '0;
         bit_cnt_q   <= '0;
         len_q       <= '0;
         type_q      <= '0;
         data_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               cmd_ready_o <= !accept;
               trstn_o     <= 1'b1;
               tms_o       <= 1'b0;
               tdi_o       <= 1'b0;
               if (accept) begin
                  len_q       <= cmd_len_i;
                  type_q      <= cmd_type_i;
                  data_q      <= cmd_data_i;
                  step_q      <= '0;
                  bit_cnt_q   <= '0;
                  rsp_data_o  <= '0;
                  rsp_err_o   <= reject;
                  rsp_valid_o <= reject;
                  if (!reject) begin
                     tms_o   <= 1'b1;
                     trstn_o <= (cmd_type_i != TAP_RESET);
                  end
               end
            end
            RST: begin
               if (tck_fall) begin
                  trstn_o <= 1'b1;
                  if (step_q == 3'd5) begin
                     tms_o       <= 1'b0;
                     rsp_valid_o <= 1'b1;
                  end else begin
                     step_q <= step_q + 3'd1;
                     tms_o  <= (step_q < 3'd4);
                  end
               end
            end
            HDR: begin
               if (tck_fall) begin
                  if (step_q == hdr_last) begin
                     bit_cnt_q <= '0;
                     tms_o     <= (len_q == 7'd1);
                     tdi_o     <= data_q[0];
                     data_q    <= data_q >> 1;
                  end else begin
                     step_q <= step_q + 3'd1;
                     tms_o  <= (type_q == SHIFT_IR) && (step_q == 3'd0);
                  end
               end
            end
            SHIFT: begin
               if (tck_rise) begin
                  rsp_data_o <= rsp_data_o | (MAX_LEN'(tdo_i) << bit_cnt_q);
                  if (last_bit) step_q <= '0;
               end
               if (tck_fall) begin
                  bit_cnt_q <= bit_cnt_q + 7'd1;
                  tdi_o     <= data_q[0];
                  data_q    <= data_q >> 1;
                  tms_o     <= ((bit_cnt_q + 7'd2) == len_q);
               end
            end
            TRL: begin
               // step 0 is the fall closing the last shift bit, then Exit1 and Update.
               if (tck_fall) begin
                  tdi_o <= 1'b0;
                  case (step_q)
                     3'd0: begin
                        tms_o  <= 1'b1;
                        step_q <= 3'd1;
                     end
                     3'd1: begin
                        tms_o  <= 1'b0;
                        step_q <= 3'd2;
                     end
                     default: begin
                        tms_o       <= 1'b0;
                        rsp_valid_o <= 1'b1;
                     end
                  endcase
               end
            end
            RESP: begin
               if (rsp_ready_i) rsp_valid_o <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adbg_jtag_host.sv
// Directed bench for adbg_jtag_host: TCK pulses are logged at each clk_i falling edge.
`timescale 1ns/1ps
module tb_adbg_jtag_host;
   import adbg_pkg::*;

   localparam int CLK_DIV = 2;
   localparam int MAX_LEN = 64;
   localparam int HN      = 512;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_type = 2'd0;
   logic [6:0]  cmd_len = 7'd0;
   logic [63:0] cmd_data = 64'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [63:0] rsp_data;
   logic        rsp_err;
   logic        tck, tms, tdi, trstn, tdo;
   logic        tdo_loop = 1'b0;
   logic        tdo_level = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   assign tdo = tdo_loop ? tdi : tdo_level;

   adbg_jtag_host #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_type_i  (cmd_type),
      .cmd_len_i   (cmd_len),
      .cmd_data_i  (cmd_data),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .rsp_err_o   (rsp_err),
      .tck_o       (tck),
      .tms_o       (tms),
      .tdi_o       (tdi),
      .trstn_o     (trstn),
      .tdo_i       (tdo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse log: pin values seen on each TCK high phase and the cycle it began.
   logic tms_h [HN];
   logic tdi_h [HN];
   logic trst_h[HN];
   int   rise_c[HN];
   int   n_rise = 0;
   int   last_fall = 0;
   logic tck_prev = 1'b0;

   always @(negedge clk) begin
      if (tck && !tck_prev) begin
         if (n_rise < HN) begin
            tms_h[n_rise]  = tms;
            tdi_h[n_rise]  = tdi;
            trst_h[n_rise] = trstn;
            rise_c[n_rise] = cyc;
         end
         n_rise++;
      end
      if (!tck && tck_prev) last_fall = cyc;
      tck_prev = tck;
   end

   function automatic logic [127:0] hist_tms(input int b, input int n);
      logic [127:0] v = '0;
      for (int i = 0; i < n && i < 128; i++) if (b + i < HN) v[i] = tms_h[b + i];
      return v;
   endfunction

   function automatic logic [127:0] hist_tdi(input int b, input int n);
      logic [127:0] v = '0;
      for (int i = 0; i < n && i < 128; i++) if (b + i < HN) v[i] = tdi_h[b + i];
      return v;
   endfunction

   task automatic issue(input logic [1:0] t, input logic [6:0] l, input logic [63:0] d,
                        output int acc);
      acc = -1;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_len   = l;
      cmd_data  = d;
      for (int n = 0; n < 64 && !cmd_ready; n++) @(negedge clk);
      if (cmd_ready) begin
         @(posedge clk);
         #1;
         acc = cyc;
      end else begin
         checks++; errors++;
         $display("FAIL accept_timeout: cmd_ready_o=%0b required 1", cmd_ready);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int rc);
      rc = -1;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (rsp_valid) begin
            rc = cyc;
            break;
         end
      end
      #1;
      if (rc < 0) begin
         checks++; errors++;
         $display("FAIL rsp_timeout: rsp_valid_o=0 required 1");
      end
   endtask

   task automatic consume(output int hc);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      hc = cyc;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({tck, tms, tdi, trstn, cmd_ready, rsp_valid, rsp_err} !== 7'b0100000 || rsp_data !== 64'd0) begin
         errors++;
         $display("FAIL reset_pins: tck,tms,tdi,trstn,rdy,vld,err=%b data=%h required 0100000 data=0",
                  {tck, tms, tdi, trstn, cmd_ready, rsp_valid, rsp_err}, rsp_data);
      end
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if ({trstn, tms, cmd_ready} !== 3'b101) begin
         errors++;
         $display("FAIL reset_release: trstn,tms,rdy=%b required 101", {trstn, tms, cmd_ready});
      end
   endtask

   task automatic test_tap_reset();
      int acc, rc, b, hc, per_bad;
      logic [5:0] rv;
      b = n_rise; tdo_loop = 1'b0; tdo_level = 1'b0;
      issue(TAP_RESET, 7'd1, 64'd0, acc);
      checks++;
      if (trstn !== 1'b0) begin
         errors++; $display("FAIL tap_reset_trst_start: trstn_o=%b required 0", trstn);
      end
      wait_rsp(rc);
      checks++;
      if (n_rise - b !== 6) begin
         errors++; $display("FAIL tap_reset_pulses: got %0d required 6", n_rise - b);
      end
      checks++;
      if (hist_tms(b, 6) !== 128'h1F) begin
         errors++; $display("FAIL tap_reset_tms: got %h required 1f", hist_tms(b, 6));
      end
      for (int i = 0; i < 6; i++) rv[i] = trst_h[b + i];
      checks++;
      if (rv !== 6'b111110) begin
         errors++; $display("FAIL tap_reset_trst: got %b required 111110", rv);
      end
      per_bad = 0;
      for (int i = 1; i < 6; i++) if (rise_c[b + i] - rise_c[b + i - 1] != 2 * CLK_DIV) per_bad++;
      checks++;
      if (per_bad !== 0 || rise_c[b] !== acc + CLK_DIV) begin
         errors++;
         $display("FAIL tap_reset_period: bad periods %0d, first rise at +%0d required 0 and +%0d",
                  per_bad, rise_c[b] - acc, CLK_DIV);
      end
      checks++;
      if (rc !== last_fall || rsp_err !== 1'b0 || rsp_data !== 64'd0 || tck !== 1'b0) begin
         errors++;
         $display("FAIL tap_reset_rsp: rc=%0d fall=%0d err=%b data=%h tck=%b required rc=fall err=0 data=0 tck=0",
                  rc, last_fall, rsp_err, rsp_data, tck);
      end
      consume(hc);
   endtask

   task automatic test_shift_dr();
      int acc, rc, b, hc;
      b = n_rise; tdo_loop = 1'b1;
      issue(SHIFT_DR, 7'd6, 64'h2A, acc);
      wait_rsp(rc);
      checks++;
      if (n_rise - b !== 11 || hist_tms(b, 11) !== 128'h301) begin
         errors++;
         $display("FAIL dr6_tms: pulses=%0d tms=%h required 11 and 301", n_rise - b, hist_tms(b, 11));
      end
      checks++;
      if (hist_tdi(b, 11) !== 128'h150) begin
         errors++; $display("FAIL dr6_tdi: got %h required 150", hist_tdi(b, 11));
      end
      checks++;
      if (rsp_data !== 64'h2A || rsp_err !== 1'b0 || rc !== last_fall) begin
         errors++;
         $display("FAIL dr6_rsp: data=%h err=%b rc=%0d fall=%0d required 2a 0 rc=fall",
                  rsp_data, rsp_err, rc, last_fall);
      end
      consume(hc);
      // Single-bit scan with TDO high: data above bit 0 must read back zero.
      b = n_rise; tdo_loop = 1'b0; tdo_level = 1'b1;
      issue(SHIFT_DR, 7'd1, 64'hFFFF_FFFF_FFFF_FFFE, acc);
      wait_rsp(rc);
      checks++;
      if (n_rise - b !== 6 || hist_tms(b, 6) !== 128'h19) begin
         errors++;
         $display("FAIL dr1_tms: pulses=%0d tms=%h required 6 and 19", n_rise - b, hist_tms(b, 6));
      end
      checks++;
      if (rsp_data !== 64'h1 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL dr1_rsp: data=%h err=%b required 1 0", rsp_data, rsp_err);
      end
      consume(hc);
   endtask

   task automatic test_shift_ir();
      int acc, rc, b, hc;
      b = n_rise; tdo_loop = 1'b0; tdo_level = 1'b1;
      issue(SHIFT_IR, 7'd4, 64'h8, acc);
      wait_rsp(rc);
      checks++;
      if (n_rise - b !== 10 || hist_tms(b, 10) !== 128'h183) begin
         errors++;
         $display("FAIL ir4_tms: pulses=%0d tms=%h required 10 and 183", n_rise - b, hist_tms(b, 10));
      end
      checks++;
      if (hist_tdi(b, 10) !== 128'h80) begin
         errors++; $display("FAIL ir4_tdi: got %h required 80", hist_tdi(b, 10));
      end
      checks++;
      if (rsp_data !== 64'hF || rsp_err !== 1'b0 || rc !== last_fall) begin
         errors++;
         $display("FAIL ir4_rsp: data=%h err=%b rc=%0d fall=%0d required f 0 rc=fall",
                  rsp_data, rsp_err, rc, last_fall);
      end
      consume(hc);
   endtask

   task automatic test_reject();
      logic [1:0] tt [3] = '{SHIFT_DR, SHIFT_DR, 2'd3};
      logic [6:0] ll [3] = '{7'd0, 7'd65, 7'd4};
      int acc, rc, b, hc;
      for (int k = 0; k < 3; k++) begin
         b = n_rise;
         issue(tt[k], ll[k], 64'hFF, acc);
         wait_rsp(rc);
         checks++;
         if (rc !== acc) begin
            errors++; $display("FAIL reject%0d_latency: rsp at +%0d required +0", k, rc - acc);
         end
         checks++;
         if (rsp_err !== 1'b1 || rsp_data !== 64'd0) begin
            errors++; $display("FAIL reject%0d_rsp: err=%b data=%h required 1 0", k, rsp_err, rsp_data);
         end
         checks++;
         if (n_rise !== b || tck !== 1'b0) begin
            errors++; $display("FAIL reject%0d_tck: pulses=%0d tck=%b required 0 0", k, n_rise - b, tck);
         end
         consume(hc);
      end
   endtask

   task automatic test_backpressure();
      int acc, rc, b, hc, bad;
      logic [63:0] d;
      d = 64'hDEAD_BEEF_0123_4567;
      b = n_rise; tdo_loop = 1'b1;
      issue(SHIFT_DR, 7'd64, d, acc);
      wait_rsp(rc);
      checks++;
      if (n_rise - b !== 69 || hist_tms(b, 69) !== ((128'd3 << 66) | 128'd1)) begin
         errors++;
         $display("FAIL dr64_tms: pulses=%0d tms=%h required 69", n_rise - b, hist_tms(b, 69));
      end
      checks++;
      if (hist_tdi(b, 69) !== (128'(d) << 3)) begin
         errors++; $display("FAIL dr64_tdi: got %h required %h", hist_tdi(b, 69), 128'(d) << 3);
      end
      bad = 0;
      for (int n = 0; n < 20; n++) begin
         if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_err !== 1'b0 ||
             cmd_ready !== 1'b0 || tck !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL dr64_hold: %0d unstable cycles required 0", bad);
      end
      consume(hc);
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL ready_gap: rdy=%b vld=%b required 0 0 after handshake", cmd_ready, rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL ready_rise: rdy=%b required 1", cmd_ready);
      end
   endtask

   task automatic test_reset_mid_shift();
      int acc, rc, b, hc, seen;
      b = n_rise; tdo_loop = 1'b0; tdo_level = 1'b0;
      issue(SHIFT_DR, 7'd20, 64'hF_FFFF, acc);
      for (int n = 0; n < 200 && (n_rise - b) < 9; n++) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({tck, tms, tdi, trstn, cmd_ready, rsp_valid} !== 6'b010000) begin
         errors++;
         $display("FAIL midreset_pins: tck,tms,tdi,trstn,rdy,vld=%b required 010000",
                  {tck, tms, tdi, trstn, cmd_ready, rsp_valid});
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      seen = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL midreset_no_rsp: rsp_valid_o high %0d cycles required 0", seen);
      end
      b = n_rise; tdo_loop = 1'b1;
      issue(SHIFT_DR, 7'd6, 64'h2A, acc);
      wait_rsp(rc);
      checks++;
      if (n_rise - b !== 11 || rsp_data !== 64'h2A || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL midreset_next: pulses=%0d data=%h err=%b required 11 2a 0",
                  n_rise - b, rsp_data, rsp_err);
      end
      consume(hc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_tap_reset();
      test_shift_dr();
      test_shift_ir();
      test_reject();
      test_backpressure();
      test_reset_mid_shift();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
